// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads 16 words, then streams (Wt, Kt) for t = 0..63.
// Define SHA256_KT_ROM_EN to build the internal Kt ROM; otherwise out_kt is 0.
module sha256_msg_schedule (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_wt,
  output logic [31:0] out_kt,
  output logic [5:0]  out_t,
  output logic        out_last
);

  typedef enum logic {LOAD, RUN} state_t;

  state_t      state;
  logic [3:0]  load_cnt;
  logic [5:0]  t;
  logic [31:0] w [16];
  logic [31:0] w_next;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  always_comb begin
    w_next = sig1(w[14]) + w[9] + sig0(w[1]) + w[0];
  end

  // in_ready/out_valid are registered copies of the state decode
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      load_cnt  <= '0;
      t         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) w[i] <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            w[load_cnt] <= in_word;
            load_cnt    <= load_cnt + 4'd1;
            if (load_cnt == 4'd15) begin
              state     <= RUN;
              t         <= '0;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        RUN: begin
          if (out_ready) begin
            for (int unsigned i = 0; i < 15; i++) w[i] <= w[i+1];
            w[15] <= w_next;
            t     <= t + 6'd1;
            if (t == 6'd63) begin
              state     <= LOAD;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign out_wt   = w[0];
  assign out_t    = t;
  assign out_last = (t == 6'd63);

`ifdef SHA256_KT_ROM_EN
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  assign out_kt = K[t];
`else
  assign out_kt = '0;
`endif

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Randomized bench for sha256_msg_schedule against a direct FIPS 180-4 schedule model.
module tb_sha256_msg_schedule;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_word = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_wt;
  logic [31:0] out_kt;
  logic [5:0]  out_t;
  logic        out_last;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] blk [16];
  logic [31:0] sched [64];

  localparam logic [31:0] KTAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  sha256_msg_schedule dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_wt    (out_wt),
    .out_kt    (out_kt),
    .out_t     (out_t),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] kt_exp(input int t);
`ifdef SHA256_KT_ROM_EN
    return KTAB[t];
`else
    return (t >= 0) ? 32'h0 : 32'h0;
`endif
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic build_sched();
    for (int i = 0; i < 16; i++) sched[i] = blk[i];
    for (int i = 16; i < 64; i++) begin
      logic [31:0] s0, s1;
      s0 = rotr(sched[i-15], 7) ^ rotr(sched[i-15], 18) ^ (sched[i-15] >> 3);
      s1 = rotr(sched[i-2], 17) ^ rotr(sched[i-2], 19) ^ (sched[i-2] >> 10);
      sched[i] = s1 + sched[i-7] + s0 + sched[i-16];
    end
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    build_sched();
  endtask

  task automatic set_random();
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    build_sched();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst in_ready", {31'b0, in_ready}, 32'd1);
    check("rst out_valid", {31'b0, out_valid}, 32'd0);
    check("rst out_t", {26'b0, out_t}, 32'd0);
    check("rst out_wt", out_wt, 32'h0);
    check("rst out_kt", out_kt, kt_exp(0));
    check("rst out_last", {31'b0, out_last}, 32'd0);
  endtask

  // Feeds the first n words of blk; gaps randomly drop in_valid.
  task automatic load_words(input int n, input bit gaps);
    int idx = 0;
    while (idx < n) begin
      @(negedge clk);
      check($sformatf("load in_ready %0d", idx), {31'b0, in_ready}, 32'd1);
      check($sformatf("load out_valid %0d", idx), {31'b0, out_valid}, 32'd0);
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_word  = in_valid ? blk[idx] : $urandom;
      @(posedge clk);
      if (in_valid) idx++;
    end
  endtask

  // Runs until stop_at words are consumed; stalls 5 cycles at bp_t when bp is set.
  task automatic run_block(input int stop_at, input bit bp, input int bp_t,
                           input bit overrun, input bit abc);
    int te = 0;
    int stalls = 0;
    for (int cyc = 0; cyc < 80 && te < stop_at; cyc++) begin
      @(negedge clk);
      check($sformatf("run out_valid t%0d", te), {31'b0, out_valid}, 32'd1);
      check($sformatf("run in_ready t%0d", te), {31'b0, in_ready}, 32'd0);
      check($sformatf("run out_t t%0d", te), {26'b0, out_t}, te);
      check($sformatf("run out_wt t%0d", te), out_wt, sched[te]);
      check($sformatf("run out_kt t%0d", te), out_kt, kt_exp(te));
      check($sformatf("run out_last t%0d", te), {31'b0, out_last}, (te == 63) ? 32'd1 : 32'd0);
      if (abc) begin
        if (te == 0)  check("abc W0", out_wt, 32'h61626380);
        if (te == 15) check("abc W15", out_wt, 32'h00000018);
        if (te == 16) check("abc W16", out_wt, 32'h61626380);
        if (te == 17) check("abc W17", out_wt, 32'h000F0000);
      end
`ifdef SHA256_KT_ROM_EN
      if (te == 0)  check("K0 literal", out_kt, 32'h428A2F98);
      if (te == 63) check("K63 literal", out_kt, 32'hC67178F2);
`endif
      if (bp && te == bp_t && stalls < 5) begin
        out_ready = 1'b0;
        stalls++;
      end else begin
        out_ready = 1'b1;
      end
      in_valid = overrun;
      in_word  = $urandom;
      @(posedge clk);
      if (out_ready) te++;
    end
    check("run words consumed", te, stop_at);
    if (stop_at == 64) begin
      @(negedge clk);
      in_valid = 1'b0;
      check("post run in_ready", {31'b0, in_ready}, 32'd1);
      check("post run out_valid", {31'b0, out_valid}, 32'd0);
      check("post run out_t", {26'b0, out_t}, 32'd0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    do_reset();

    set_abc();
    load_words(16, 1'b0);
    run_block(64, 1'b0, 0, 1'b0, 1'b1);

    set_random();
    load_words(16, 1'b1);
    run_block(64, 1'b1, 20, 1'b1, 1'b0);

    set_abc();
    load_words(7, 1'b0);
    do_reset();
    load_words(16, 1'b0);
    run_block(30, 1'b0, 0, 1'b0, 1'b1);
    do_reset();
    load_words(16, 1'b1);
    run_block(64, 1'b0, 0, 1'b0, 1'b1);

    for (int b = 0; b < 3; b++) begin
      set_random();
      load_words(16, b == 1);
      run_block(64, b == 2, $urandom_range(0, 63), b == 0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
